// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops sharing a runtime mode (D, T, SR, JK) with sticky SR-conflict flags.
// Define MULTIMODE_FF_ERR_CNT_EN to add the saturating conflict event counter and err_cnt port.
module multimode_ff_bank #(
   parameter int unsigned         WIDTH     = 8,
   parameter logic [WIDTH-1:0]    RESET_VAL = '0,
   parameter int unsigned         CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              err_clr,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qbar,
`ifdef MULTIMODE_FF_ERR_CNT_EN
   output logic [CNT_W-1:0]  err_cnt,
`endif
   output logic [WIDTH-1:0]  err
);

   typedef enum logic [1:0] {
      ModeD  = 2'b00,
      ModeT  = 2'b01,
      ModeSr = 2'b10,
      ModeJk = 2'b11
   } mode_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] err_q, err_d;
   logic [WIDTH-1:0] conflict;

   assign conflict = (en && (mode_e'(mode) == ModeSr)) ? (a & b) : '0;

   always_comb begin
      q_d = q_q;
      if (en) begin
         unique case (mode_e'(mode))
            ModeD:  q_d = a;
            ModeT:  q_d = q_q ^ a;
            // Set wins where only S is high, clear where only R is high; 11 holds.
            ModeSr: q_d = (q_q & ~(b & ~a)) | (a & ~b);
            ModeJk: q_d = (a & ~q_q) | (~b & q_q);
         endcase
      end
   end

   // A conflict in the clearing cycle survives the clear.
   always_comb begin
      err_d = err_q | conflict;
      if (err_clr) begin
         err_d = conflict;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q   <= RESET_VAL;
         err_q <= '0;
      end else begin
         q_q   <= q_d;
         err_q <= err_d;
      end
   end

   assign q    = q_q;
   assign qbar = ~q_q;
   assign err  = err_q;

`ifdef MULTIMODE_FF_ERR_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             conflict_event;

   assign conflict_event = |conflict;

   always_comb begin
      cnt_d = cnt_q;
      if (err_clr) begin
         cnt_d = conflict_event ? CNT_W'(1) : '0;
      end else if (conflict_event && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed self-checking bench for multimode_ff_bank (WIDTH=8, RESET_VAL=0xA5, CNT_W=3).
module tb_multimode_ff_bank;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [7:0] a;
   logic [7:0] b;
   logic       err_clr;
   logic [7:0] q;
   logic [7:0] qbar;
   logic [7:0] err;
`ifdef MULTIMODE_FF_ERR_CNT_EN
   logic [2:0] err_cnt;
`endif

   int checks;
   int errors;

   localparam logic [1:0] MD = 2'b00, MT = 2'b01, MSR = 2'b10, MJK = 2'b11;

   multimode_ff_bank #(
      .WIDTH    (8),
      .RESET_VAL(8'hA5),
      .CNT_W    (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .err_clr(err_clr),
      .q      (q),
      .qbar   (qbar),
`ifdef MULTIMODE_FF_ERR_CNT_EN
      .err_cnt(err_cnt),
`endif
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_q(input string tag, input logic [7:0] exp);
      check({tag, ".q"}, q, exp);
      check({tag, ".qbar"}, qbar, ~exp);
   endtask

   task automatic check_cnt(input string tag, input logic [7:0] exp);
`ifdef MULTIMODE_FF_ERR_CNT_EN
      check({tag, ".cnt"}, 8'(err_cnt), exp);
`endif
   endtask

   task automatic drive(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] va, input logic [7:0] vb, input logic c);
      rst = r; en = e; mode = m; a = va; b = vb; err_clr = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive(1'b1, 1'b0, MD, 8'h00, 8'h00, 1'b0);
      tick();
      check_q("reset", 8'hA5);
      check("reset.err", err, 8'h00);
      check_cnt("reset", 8'd0);

      drive(1'b1, 1'b1, MD, 8'hFF, 8'h00, 1'b0);
      tick();
      check_q("reset_over_d", 8'hA5);

      drive(1'b0, 1'b1, MD, 8'h3C, 8'h00, 1'b0);
      tick();
      check_q("d", 8'h3C);

      drive(1'b0, 1'b1, MT, 8'h0F, 8'h00, 1'b0);
      tick();
      check_q("t1", 8'h33);
      tick();
      check_q("t2", 8'h3C);

      drive(1'b0, 1'b0, MT, 8'hFF, 8'h00, 1'b0);
      tick();
      check_q("en_low", 8'h3C);

      drive(1'b0, 1'b1, MD, 8'h00, 8'h00, 1'b0);
      tick();
      check_q("d_zero", 8'h00);

      drive(1'b0, 1'b1, MSR, 8'hF0, 8'h0F, 1'b0);
      tick();
      check_q("sr_set", 8'hF0);
      check("sr_set.err", err, 8'h00);

      drive(1'b0, 1'b1, MSR, 8'h81, 8'h81, 1'b0);
      tick();
      check_q("sr_conf", 8'hF0);
      check("sr_conf.err", err, 8'h81);
      check_cnt("sr_conf", 8'd1);

      drive(1'b0, 1'b1, MJK, 8'hFF, 8'hFF, 1'b0);
      tick();
      check_q("jk1", 8'h0F);
      check("jk1.err", err, 8'h81);
      check_cnt("jk1", 8'd1);
      tick();
      check_q("jk2", 8'hF0);
      check("jk2.err", err, 8'h81);

      drive(1'b0, 1'b1, MJK, 8'h0C, 8'h30, 1'b0);
      tick();
      check_q("jk_setclr", 8'hCC);

      drive(1'b0, 1'b1, MSR, 8'h81, 8'h81, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check_q("sr_conf4", 8'hCC);
      check("sr_conf4.err", err, 8'h81);
      check_cnt("sr_conf4", 8'd5);

      drive(1'b0, 1'b1, MSR, 8'h04, 8'h04, 1'b1);
      tick();
      check("clr_evt.err", err, 8'h04);
      check_cnt("clr_evt", 8'd1);
      check_q("clr_evt", 8'hCC);

      drive(1'b0, 1'b0, MSR, 8'h00, 8'h00, 1'b1);
      tick();
      check("clr_en_low.err", err, 8'h00);
      check_cnt("clr_en_low", 8'd0);

      drive(1'b0, 1'b0, MSR, 8'hFF, 8'hFF, 1'b0);
      tick();
      check("sr_en_low.err", err, 8'h00);
      check_cnt("sr_en_low", 8'd0);

      drive(1'b0, 1'b1, MSR, 8'h01, 8'h01, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      check("sat.err", err, 8'h01);
      check_cnt("sat", 8'd7);
      tick();
      check_cnt("sat_hold", 8'd7);

      drive(1'b0, 1'b1, MSR, 8'h00, 8'h00, 1'b0);
      tick();
      check("sticky.err", err, 8'h01);
      check_q("sticky", 8'hCC);

      drive(1'b1, 1'b1, MSR, 8'hFF, 8'hFF, 1'b0);
      tick();
      check_q("mid_reset", 8'hA5);
      check("mid_reset.err", err, 8'h00);
      check_cnt("mid_reset", 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
